// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control-unit to program-counter sequencer bundle
interface pc_sequencer_if #(
    parameter int AW    = 10,
    parameter int DEPTH = 8
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic           stall;
    logic [2:0]     op;
    logic           zero;
    logic [AW-1:0]  target;
    logic [AW-1:0]  rel_off;
    logic           irq;

    logic [AW-1:0]  pc;
    logic [SPW-1:0] sp;
    logic           stack_full;
    logic           stack_empty;
    logic           ovf;
    logic           unf;
    logic           irq_ack;
    logic           in_isr;

    modport master (
        output stall, op, zero, target, rel_off, irq,
        input  pc, sp, stack_full, stack_empty, ovf, unf, irq_ack, in_isr
    );

    modport slave (
        input  stall, op, zero, target, rel_off, irq,
        output pc, sp, stack_full, stack_empty, ovf, unf, irq_ack, in_isr
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with return stack, branches and optional IRQ entry (PCSEQ_IRQ_EN)
module pc_sequencer #(
    parameter int            AW         = 10,
    parameter int            DEPTH      = 8,
    parameter logic [AW-1:0] IRQ_VECTOR = '0
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);

    localparam logic [2:0] OP_INC  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JREL = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_BZ   = 3'b101;
    localparam logic [2:0] OP_BNZ  = 3'b110;
    localparam logic [2:0] OP_RETI = 3'b111;

    logic [AW-1:0]  pc_r;
    logic [SPW-1:0] sp_r;
    logic [AW-1:0]  mem [DEPTH];
    logic           ovf_r;
    logic           unf_r;
    logic           ack_r;
    logic           isr_r;

    logic           full;
    logic           empty;
    logic [AW-1:0]  pc_inc;
    logic [SPW-1:0] sp_dec;
    logic [AW-1:0]  top;

    logic           take;
    logic           push;
    logic           pop;
    logic [AW-1:0]  push_val;
    logic [AW-1:0]  pc_nxt;
    logic           set_ovf;
    logic           set_unf;
    logic           clr_isr;

    assign full   = (sp_r == SPW'(DEPTH));
    assign empty  = (sp_r == '0);
    assign pc_inc = pc_r + AW'(1);
    assign sp_dec = sp_r - SPW'(1);
    assign top    = mem[sp_dec[IW-1:0]];

`ifdef PCSEQ_IRQ_EN
    // Deferred, not dropped, while the stack cannot take the return address.
    assign take = bus.irq && !isr_r && !full;
`else
    logic unused_irq;
    assign unused_irq = bus.irq;
    assign take       = 1'b0;
`endif

    always_comb begin
        pc_nxt   = pc_inc;
        push     = 1'b0;
        pop      = 1'b0;
        push_val = pc_inc;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        clr_isr  = 1'b0;
        if (take) begin
            // The suppressed instruction is re-executed after RETI.
            push     = 1'b1;
            push_val = pc_r;
            pc_nxt   = IRQ_VECTOR;
        end else begin
            case (bus.op)
                OP_INC:  pc_nxt = pc_inc;
                OP_JMP:  pc_nxt = bus.target;
                OP_JREL: pc_nxt = pc_r + bus.rel_off;
                OP_CALL: begin
                    if (!full) begin
                        push   = 1'b1;
                        pc_nxt = bus.target;
                    end else begin
                        set_ovf = 1'b1;
                    end
                end
                OP_RET, OP_RETI: begin
                    if (!empty) begin
                        pop    = 1'b1;
                        pc_nxt = top;
                    end else begin
                        set_unf = 1'b1;
                    end
`ifdef PCSEQ_IRQ_EN
                    clr_isr = (bus.op == OP_RETI);
`endif
                end
                OP_BZ:   pc_nxt = bus.zero ? bus.target : pc_inc;
                OP_BNZ:  pc_nxt = bus.zero ? pc_inc : bus.target;
                default: pc_nxt = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r  <= '0;
            sp_r  <= '0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
            ack_r <= 1'b0;
            isr_r <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            if (!bus.stall) begin
                pc_r <= pc_nxt;
                if (push) begin
                    mem[sp_r[IW-1:0]] <= push_val;
                    sp_r              <= sp_r + SPW'(1);
                end else if (pop) begin
                    sp_r <= sp_dec;
                end
                if (set_ovf) ovf_r <= 1'b1;
                if (set_unf) unf_r <= 1'b1;
                if (take) begin
                    isr_r <= 1'b1;
                    ack_r <= 1'b1;
                end else if (clr_isr) begin
                    isr_r <= 1'b0;
                end
            end
        end
    end

    assign bus.pc          = pc_r;
    assign bus.sp          = sp_r;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.ovf         = ovf_r;
    assign bus.unf         = unf_r;
    assign bus.irq_ack     = ack_r;
    assign bus.in_isr      = isr_r;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - vector table, corner sequences and random run against a stack model
module tb_pc_sequencer;
    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int MODV  = 1 << AW;
    localparam logic [AW-1:0] VEC = 10'h300;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_sequencer_if #(.AW(AW), .DEPTH(DEPTH)) bus ();
    pc_sequencer #(.AW(AW), .DEPTH(DEPTH), .IRQ_VECTOR(VEC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int m_pc;
    int m_stk[$];
    bit m_ovf, m_unf, m_ack, m_isr;

    typedef struct {
        logic [2:0]    op;
        logic          zero;
        logic [AW-1:0] target;
        logic [AW-1:0] rel;
        logic          stall;
        int            e_pc;
        int            e_sp;
        bit            e_ovf;
        bit            e_unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] o, input logic z, input int t, input int r,
                                input logic s, input int ep, input int es, input bit eo, input bit eu);
        vec_t v;
        v.op = o; v.zero = z; v.target = AW'(t); v.rel = AW'(r); v.stall = s;
        v.e_pc = ep; v.e_sp = es; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0; m_ack = 0; m_isr = 0;
    endtask

    task automatic model_step(input logic [2:0] o, input logic z, input int t, input int r,
                              input logic st, input logic iq);
        int inc;
        m_ack = 0;
        if (st) return;
        inc = (m_pc + 1) % MODV;
`ifdef PCSEQ_IRQ_EN
        if (iq && !m_isr && m_stk.size() < DEPTH) begin
            m_stk.push_back(m_pc);
            m_pc = int'(VEC); m_isr = 1; m_ack = 1;
            return;
        end
`endif
        case (o)
            3'd0: m_pc = inc;
            3'd1: m_pc = t;
            3'd2: m_pc = (m_pc + r) % MODV;
            3'd3: if (m_stk.size() < DEPTH) begin m_stk.push_back(inc); m_pc = t; end
                  else begin m_ovf = 1; m_pc = inc; end
            3'd5: m_pc = z ? t : inc;
            3'd6: m_pc = z ? inc : t;
            default: begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_unf = 1; m_pc = inc; end
`ifdef PCSEQ_IRQ_EN
                if (o == 3'd7) m_isr = 0;
`endif
            end
        endcase
    endtask

    task automatic drive_edge(input logic [2:0] o, input logic z, input int t, input int r,
                              input logic st, input logic iq);
        bus.op = o; bus.zero = z; bus.target = AW'(t); bus.rel_off = AW'(r);
        bus.stall = st; bus.irq = iq;
        model_step(o, z, t, r, st, iq);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"}, int'(bus.pc), m_pc);
        chk({tag, ".sp"}, int'(bus.sp), m_stk.size());
        chk({tag, ".full"}, int'(bus.stack_full), int'(m_stk.size() == DEPTH));
        chk({tag, ".empty"}, int'(bus.stack_empty), int'(m_stk.size() == 0));
        chk({tag, ".ovf"}, int'(bus.ovf), int'(m_ovf));
        chk({tag, ".unf"}, int'(bus.unf), int'(m_unf));
        chk({tag, ".irq_ack"}, int'(bus.irq_ack), int'(m_ack));
        chk({tag, ".in_isr"}, int'(bus.in_isr), int'(m_isr));
    endtask

    initial begin
        bus.op = 3'd0; bus.zero = 1'b0; bus.target = '0; bus.rel_off = '0;
        bus.stall = 1'b1; bus.irq = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("reset.pc", int'(bus.pc), 0);
        chk("reset.sp", int'(bus.sp), 0);
        chk("reset.empty", int'(bus.stack_empty), 1);
        chk("reset.full", int'(bus.stack_full), 0);
        chk("reset.ovf", int'(bus.ovf), 0);
        chk("reset.unf", int'(bus.unf), 0);
        chk("reset.ack", int'(bus.irq_ack), 0);
        chk("reset.isr", int'(bus.in_isr), 0);

        for (int i = 1; i <= 5; i++) tbl.push_back(mk(3'd0, 0, 0, 0, 0, i, 0, 0, 0));
        tbl.push_back(mk(3'd1, 0, 'h3FF, 0, 0, 'h3FF, 0, 0, 0));
        tbl.push_back(mk(3'd0, 0, 0, 0, 0, 'h000, 0, 0, 0));
        tbl.push_back(mk(3'd1, 0, 'h005, 0, 0, 'h005, 0, 0, 0));
        tbl.push_back(mk(3'd2, 0, 0, 'h3FD, 0, 'h002, 0, 0, 0));
        tbl.push_back(mk(3'd1, 0, 'h010, 0, 0, 'h010, 0, 0, 0));
        tbl.push_back(mk(3'd3, 0, 'h100, 0, 0, 'h100, 1, 0, 0));
        tbl.push_back(mk(3'd4, 0, 0, 0, 0, 'h011, 0, 0, 0));
        tbl.push_back(mk(3'd1, 0, 'h020, 0, 0, 'h020, 0, 0, 0));
        for (int i = 1; i <= 4; i++) tbl.push_back(mk(3'd3, 0, 'h040, 0, 0, 'h040, i, 0, 0));
        tbl.push_back(mk(3'd3, 0, 'h040, 0, 0, 'h041, 4, 1, 0));
        tbl.push_back(mk(3'd4, 0, 0, 0, 0, 'h041, 3, 1, 0));
        tbl.push_back(mk(3'd4, 0, 0, 0, 0, 'h041, 2, 1, 0));
        tbl.push_back(mk(3'd4, 0, 0, 0, 0, 'h041, 1, 1, 0));
        tbl.push_back(mk(3'd4, 0, 0, 0, 0, 'h021, 0, 1, 0));
        tbl.push_back(mk(3'd4, 0, 0, 0, 0, 'h022, 0, 1, 1));
        tbl.push_back(mk(3'd5, 1, 'h200, 0, 0, 'h200, 0, 1, 1));
        tbl.push_back(mk(3'd5, 0, 'h200, 0, 0, 'h201, 0, 1, 1));
        tbl.push_back(mk(3'd1, 0, 'h123, 0, 1, 'h201, 0, 1, 1));
        tbl.push_back(mk(3'd6, 0, 'h300, 0, 0, 'h300, 0, 1, 1));
        tbl.push_back(mk(3'd6, 1, 'h300, 0, 0, 'h301, 0, 1, 1));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 'h302, 0, 1, 1));

        foreach (tbl[i]) begin
            drive_edge(tbl[i].op, tbl[i].zero, int'(tbl[i].target), int'(tbl[i].rel), tbl[i].stall, 1'b0);
            chk($sformatf("vec%0d.pc", i), int'(bus.pc), tbl[i].e_pc);
            chk($sformatf("vec%0d.sp", i), int'(bus.sp), tbl[i].e_sp);
            chk($sformatf("vec%0d.full", i), int'(bus.stack_full), int'(tbl[i].e_sp == DEPTH));
            chk($sformatf("vec%0d.empty", i), int'(bus.stack_empty), int'(tbl[i].e_sp == 0));
            chk($sformatf("vec%0d.ovf", i), int'(bus.ovf), int'(tbl[i].e_ovf));
            chk($sformatf("vec%0d.unf", i), int'(bus.unf), int'(tbl[i].e_unf));
        end

        // Reset in the middle of a call chain, while stalled, discards the stack.
        drive_edge(3'd3, 0, 'h050, 0, 0, 0);
        drive_edge(3'd3, 0, 'h060, 0, 0, 0);
        chk("midcall.sp_before", int'(bus.sp), 2);
        bus.stall = 1'b1;
        do_reset();
        chk("midcall.pc", int'(bus.pc), 0);
        chk("midcall.sp", int'(bus.sp), 0);
        chk("midcall.empty", int'(bus.stack_empty), 1);
        chk("midcall.ovf", int'(bus.ovf), 0);
        chk("midcall.unf", int'(bus.unf), 0);
        drive_edge(3'd4, 0, 0, 0, 0, 0);
        chk("midcall.ret_unf", int'(bus.unf), 1);
        chk("midcall.ret_pc", int'(bus.pc), 1);

        do_reset();
        drive_edge(3'd1, 0, 'h050, 0, 0, 0);
`ifdef PCSEQ_IRQ_EN
        drive_edge(3'd1, 0, 'h080, 0, 0, 1);
        chk("irq.pc", int'(bus.pc), 'h300);
        chk("irq.ack", int'(bus.irq_ack), 1);
        chk("irq.isr", int'(bus.in_isr), 1);
        chk("irq.sp", int'(bus.sp), 1);
        drive_edge(3'd0, 0, 0, 0, 0, 1);
        chk("irq.noreenter_pc", int'(bus.pc), 'h301);
        chk("irq.ack_pulse", int'(bus.irq_ack), 0);
        chk("irq.isr_hold", int'(bus.in_isr), 1);
        drive_edge(3'd7, 0, 0, 0, 0, 0);
        chk("reti.pc", int'(bus.pc), 'h050);
        chk("reti.isr", int'(bus.in_isr), 0);
        chk("reti.sp", int'(bus.sp), 0);
        for (int i = 0; i < DEPTH; i++) drive_edge(3'd3, 0, 'h100 + i, 0, 0, 0);
        drive_edge(3'd0, 0, 0, 0, 0, 1);
        chk("irq_full.deferred_pc", int'(bus.pc), 'h104);
        chk("irq_full.no_ovf", int'(bus.ovf), 0);
        chk("irq_full.no_ack", int'(bus.irq_ack), 0);
        drive_edge(3'd4, 0, 0, 0, 0, 1);
        drive_edge(3'd0, 0, 0, 0, 0, 1);
        chk("irq_full.taken_pc", int'(bus.pc), 'h300);
        chk("irq_full.taken_ack", int'(bus.irq_ack), 1);
`else
        drive_edge(3'd1, 0, 'h080, 0, 0, 1);
        chk("noirq.pc", int'(bus.pc), 'h080);
        chk("noirq.ack", int'(bus.irq_ack), 0);
        chk("noirq.isr", int'(bus.in_isr), 0);
        chk("noirq.sp", int'(bus.sp), 0);
`endif

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                bus.stall = 1'($urandom_range(0, 1));
                do_reset();
            end else begin
                drive_edge(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                           int'($urandom_range(0, MODV - 1)), int'($urandom_range(0, MODV - 1)),
                           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0));
            end
            check_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
